// File: rtl/text_pkg.sv
// ============================================================================
//  text_pkg
//  Shared constants and helpers for the VGA text path.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package text_pkg;

  localparam logic [6:0] ASCII_ZERO  = 7'h30;
  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [3:0] BCD_MAX     = 4'd9;

  // Counter width for n states, never narrower than one bit.
  function automatic int safe_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
//  bcd_digit
//  One decade of an up/down BCD counter with chained carry/borrow.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module bcd_digit
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       adv_in,
  input  logic       up,
  output logic [3:0] value,
  output logic       carry_out
);

  logic [3:0] value_q;
  logic [3:0] value_d;

  assign value     = value_q;
  assign carry_out = adv_in && (up ? (value_q == BCD_MAX) : (value_q == 4'd0));

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = 4'd0;
    end else if (adv_in) begin
      if (up) begin
        value_d = (value_q == BCD_MAX) ? 4'd0 : value_q + 4'd1;
      end else begin
        value_d = (value_q == 4'd0) ? BCD_MAX : value_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= 4'd0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ascii_bcd_counter.sv
// ============================================================================
//  ascii_bcd_counter
//  Prescaled multi-digit up/down BCD counter with ASCII digit outputs.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ascii_bcd_counter
  import text_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  step,
  input  logic                  blank,
  output logic [7*DIGITS-1:0]   ascii,
  output logic                  tick,
  output logic                  wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = safe_width(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  if (DIV < 1 || DIGITS < 1 || DIGITS > 8) begin : g_param_check
    $error("ascii_bcd_counter: DIV must be >= 1 and DIGITS in 1..8");
  end

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic          tick_q;
  logic          wrap_q;
  logic          adv;
  logic [DIGITS:0] adv_chain;
  logic [3:0]    digit_val [DIGITS];
  logic [DIGITS-1:0] upper_zero;

  // Timed and manual advances collapse into one; clr is resolved in the digits.
  assign adv          = (en && (presc_q == PRESC_LAST)) || step;
  assign adv_chain[0] = adv;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr       (clr),
      .adv_in    (adv_chain[i]),
      .up        (up),
      .value     (digit_val[i]),
      .carry_out (adv_chain[i+1])
    );
  end

  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= adv && !clr;
      wrap_q  <= adv_chain[DIGITS] && !clr;
    end
  end

  assign tick = tick_q;
  assign wrap = wrap_q;

  // upper_zero[i]: digits i..DIGITS-1 are all zero, so digit i is a leading zero.
  always_comb begin
    upper_zero = '0;
    ascii      = '0;
    upper_zero[DIGITS-1] = (digit_val[DIGITS-1] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (digit_val[i] == 4'd0);
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (blank && (i != 0) && upper_zero[i]) begin
        ascii[7*i +: 7] = ASCII_SPACE;
      end else begin
        ascii[7*i +: 7] = ASCII_ZERO + {3'b000, digit_val[i]};
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/ascii_bcd_counter.md
# ascii_bcd_counter

Parametrised multi-digit decimal counter for the VGA text path. It advances a DIGITS-wide BCD count at TICK_HZ, derived from the CLK_HZ system clock, and presents each digit as a 7-bit ASCII code ready for the character ROM. It generalises the single-digit 1 Hz ASCII counter with up/down counting, enable, synchronous clear, manual step, leading-zero blanking, and tick/wrap strobes.

## Interface
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 1, count rate; DIV = CLK_HZ/TICK_HZ (integer, truncated); DIV < 1 is an elaboration error.
- DIGITS, 4, number of decimal digits (1..8).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  1 = prescaler runs and count advances on terminal count; 0 = prescaler and count hold.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear of count and prescaler.
- step  in  1  single-cycle manual advance, honoured regardless of en.
- blank  in  1  1 = leading zeros shown as ASCII space.
- ascii  out  7*DIGITS  digit i at [7i+6:7i]; digit 0 is least significant.
- tick  out  1  one-cycle pulse in the first cycle a new count is visible.
- wrap  out  1  one-cycle pulse coincident with tick when the count wraps.

## Operation
- Prescaler: width $clog2(DIV) (min 1); counts 0..DIV-1 while en=1, then returns to 0.
- adv = (en && presc == DIV-1) || step. At most one advance per cycle, even if both terms are true.
- Up: digit 0 increments; 9→0 carries into the next digit. Down: 0→9 borrows.
- Up wrap: all-9 → all-0. Down wrap: all-0 → all-9. Either sets wrap.
- Priority: clr > adv. clr zeroes the digits and prescaler, suppresses tick/wrap that cycle, and discards a simultaneous step.
- up may change at any time; it is sampled in the adv cycle only.
- ascii mapping: digit d → 0x30+d.
- Blanking: with blank=1, digit i>0 maps to 0x20 when digits i..DIGITS-1 are all zero. Digit 0 is never blanked.
- blank is combinational on ascii and has no state effect.
- Digit registers hold only 0..9. No illegal BCD states are reachable.

## Timing
- Reset (reset_n=0, immediate, no clock needed): digits=0, prescaler=0, tick=0, wrap=0.
- ascii in reset: all 0x30, or with blank=1 all 0x20 except digit 0 = 0x30.
- Deassertion is synchronous to the next clk edge; the first prescaler increment occurs on that edge if en=1.
- From reset release with en=1, the first timed advance lands on edge DIV. Timed advances repeat every DIV cycles.
- tick and wrap are registered and assert in the same cycle the new digits appear.
- ascii is a combinational decode of the digit registers: zero added latency.
- en=0 freezes the prescaler value. Re-enabling resumes from the frozen value, with no phase reset.
- DIV=1 with en=1: the count advances every cycle, and tick stays high continuously.
- reset_n asserted mid-count: all state clears asynchronously. A pulse in flight on tick/wrap is dropped.

## Structure
- Shared package/include text_pkg: ASCII_ZERO=7'h30, ASCII_SPACE=7'h20, function clog2-safe width helper. Other text-path blocks use the same constants.
- Sub-module bcd_digit: one decade.
  - Inputs: clk, reset_n, clr, adv_in, up.
  - Outputs: 4-bit value, carry_out (value==9 with up, or value==0 with !up, ANDed with adv_in).
- Top level: generate-chains DIGITS instances, adv_in[i+1] = carry_out[i]; wrap = carry_out[DIGITS-1].
- Top level also holds the prescaler, tick/wrap registers and the ASCII/blank decode.

## Test plan
Bench uses CLK_HZ=10, TICK_HZ=1 (DIV=10), DIGITS=3.
- Reset, en=1, up=1: after edge 10, ascii={0x30,0x30,0x31}; tick high exactly 1 cycle, then every 10 cycles.
- step×999 (en=0) → "999"; next step → "000" with tick=1, wrap=1 for one cycle.
- From "000", up=0, step → "999", wrap=1. Then en=1 with prescaler at 4 and step asserted on the terminal cycle → exactly one decrement to "998".
- blank=1: count 7 → {0x20,0x20,0x37}; count 105 → {0x31,0x30,0x35}; count 0 → {0x20,0x20,0x30}.
- en=0 at prescaler=6 for 20 cycles → no tick. Re-enable → tick after 4 cycles. clr with step in the same cycle → "000", tick=0, prescaler=0.
- reset_n low between edges at count "042" → ascii all 0x30 and tick/wrap 0 before the next clk edge.
